// File: rtl/result_collector_if.sv
// result_collector_if: input result-pair and output word-stream signals of result_collector (slave = collector side)
interface result_collector_if #(
  parameter int DEPTH = 8
);
  logic                    in_valid_i;
  logic [7:0]              result_i;
  logic [7:0]              result_2_i;
  logic [15:0]             m_data_o;
  logic                    m_valid_o;
  logic                    m_ready_i;
  logic                    m_last_o;
  logic [$clog2(DEPTH):0]  fill_o;
  logic                    overflow_o;
  logic [15:0]             checksum_o;
  modport master (
    output in_valid_i, result_i, result_2_i, m_ready_i,
    input  m_data_o, m_valid_o, m_last_o, fill_o, overflow_o, checksum_o
  );
  modport slave (
    input  in_valid_i, result_i, result_2_i, m_ready_i,
    output m_data_o, m_valid_o, m_last_o, fill_o, overflow_o, checksum_o
  );
endinterface

// File: rtl/result_collector.sv
// result_collector: packs result pairs into framed 16-bit words via a FIFO onto a valid/ready stream; RESULT_COLLECTOR_CHECKSUM_EN adds a per-frame checksum
module result_collector #(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  logic [16:0]   mem_q [DEPTH];
  logic [16:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] frm_cnt_q, frm_cnt_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, last;
  logic [15:0]   word;
  always_comb begin
    word       = {bus.result_2_i, bus.result_i};
    pop        = (count_q != '0) && bus.m_ready_i;
    push       = bus.in_valid_i && ((count_q != CW'(DEPTH)) || pop);
    last       = frm_cnt_q == FW'(FRAME_LEN - 1);
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = {last, word};
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    frm_cnt_d  = !push ? frm_cnt_q : last ? '0 : frm_cnt_q + FW'(1);
    overflow_d = overflow_q | (bus.in_valid_i && !push);
  end
  always_ff @(posedge clk_i) mem_q <= mem_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      frm_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      frm_cnt_q  <= frm_cnt_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.m_valid_o  = count_q != '0;
  assign bus.m_data_o   = bus.m_valid_o ? mem_q[rd_ptr_q][15:0] : '0;
  assign bus.m_last_o   = bus.m_valid_o & mem_q[rd_ptr_q][16];
  assign bus.fill_o     = count_q;
  assign bus.overflow_o = overflow_q;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  logic [15:0] frm_sum_q, frm_sum_d, checksum_q, checksum_d;
  always_comb begin
    frm_sum_d  = !push ? frm_sum_q : last ? '0 : frm_sum_q + word;
    checksum_d = (push && last) ? frm_sum_q + word : checksum_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frm_sum_q  <= '0;
      checksum_q <= '0;
    end else begin
      frm_sum_q  <= frm_sum_d;
      checksum_q <= checksum_d;
    end
  end
  assign bus.checksum_o = checksum_q;
`else
  assign bus.checksum_o = '0;
`endif
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed table-driven and sequence checks of result_collector (DEPTH=8, FRAME_LEN=4)
module tb_result_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  result_collector_if #(.DEPTH(8)) bus();
  result_collector #(.DEPTH(8), .FRAME_LEN(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
  localparam logic [15:0] CK_A  = 16'h000A;
  localparam logic [15:0] CK_AA = 16'h00AA;
`else
  localparam logic [15:0] CK_A  = 16'h0000;
  localparam logic [15:0] CK_AA = 16'h0000;
`endif
  typedef struct {
    logic        v;
    logic [15:0] w;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic [3:0]  ef;
    logic [15:0] ec;
  } vec_t;
  vec_t tbl [8];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] w, input logic rdy);
    bus.in_valid_i = v;
    bus.result_i   = w[7:0];
    bus.result_2_i = w[15:8];
    bus.m_ready_i  = rdy;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
  endtask
  initial begin
    tbl[0] = '{1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b0, 4'd1, 16'h0000};
    tbl[1] = '{1'b1, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b0, 4'd1, 16'h0000};
    tbl[2] = '{1'b1, 16'h0003, 1'b1, 1'b1, 16'h0003, 1'b0, 4'd1, 16'h0000};
    tbl[3] = '{1'b1, 16'h0004, 1'b1, 1'b1, 16'h0004, 1'b1, 4'd1, CK_A};
    tbl[4] = '{1'b1, 16'h0005, 1'b1, 1'b1, 16'h0005, 1'b0, 4'd1, CK_A};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, CK_A};
    tbl[6] = '{1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 1'b0, 4'd1, CK_A};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, CK_A};
    do_reset();
    step(1'b0, 16'h0, 1'b0);
    chk("reset_valid", bus.m_valid_o, 0);
    chk("reset_fill", bus.fill_o, 0);
    chk("reset_ovf", bus.overflow_o, 0);
    chk("reset_cks", bus.checksum_o, 0);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].w, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), bus.m_valid_o, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_data", i), bus.m_data_o, tbl[i].ed);
        chk($sformatf("vec%0d_last", i), bus.m_last_o, tbl[i].el);
      end
      chk($sformatf("vec%0d_fill", i), bus.fill_o, tbl[i].ef);
      chk($sformatf("vec%0d_ovf", i), bus.overflow_o, 0);
      chk($sformatf("vec%0d_cks", i), bus.checksum_o, tbl[i].ec);
    end
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, {8'hB0, 8'(i)}, 1'b0);
      if (i == 7) begin
        chk("ovf_before_drop", bus.overflow_o, 0);
        chk("ovf_fill_full", bus.fill_o, 8);
      end
    end
    chk("ovf_fill", bus.fill_o, 8);
    chk("ovf_flag", bus.overflow_o, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_drain%0d_valid", i), bus.m_valid_o, 1);
      chk($sformatf("ovf_drain%0d_data", i), bus.m_data_o, {16'h0, 8'hB0, 8'(i)});
      chk($sformatf("ovf_drain%0d_last", i), bus.m_last_o, (i % 4) == 3);
      step(1'b0, 16'h0, 1'b1);
    end
    chk("ovf_empty_valid", bus.m_valid_o, 0);
    chk("ovf_empty_fill", bus.fill_o, 0);
    chk("ovf_sticky", bus.overflow_o, 1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, {8'hC0, 8'(i)}, 1'b0);
    step(1'b1, 16'h55AA, 1'b1);
    chk("fullpop_fill", bus.fill_o, 8);
    chk("fullpop_ovf", bus.overflow_o, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fullpop_drain%0d", i), bus.m_data_o, i < 7 ? {16'h0, 8'hC0, 8'(i + 1)} : 32'h55AA);
      step(1'b0, 16'h0, 1'b1);
    end
    chk("fullpop_empty", bus.fill_o, 0);
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, {8'hD0, 8'(i)}, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    chk("mid_fill3", bus.fill_o, 3);
    chk("mid_ovf1", bus.overflow_o, 1);
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    chk("mid_rst_valid", bus.m_valid_o, 0);
    chk("mid_rst_ovf", bus.overflow_o, 0);
    chk("mid_rst_fill", bus.fill_o, 0);
    chk("mid_rst_cks", bus.checksum_o, 0);
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i * 16'h0011), 1'b0);
    chk("mid_cks", bus.checksum_o, CK_AA);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_data%0d", i), bus.m_data_o, (i + 1) * 32'h0011);
      chk($sformatf("mid_last%0d", i), bus.m_last_o, i == 3);
      step(1'b0, 16'h0, 1'b1);
    end
    chk("mid_empty", bus.m_valid_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage of the dual-lane add/multiply/add datapath. Captures the `result`/`result_2` byte pair the datapath produces every `clk_100meg` cycle and packs each pair into a 16-bit word. Buffers the words in a small FIFO and tags frame boundaries. Presents the words on a valid/ready stream to the consumer, flagging any pair lost to back-pressure.

## Interface

Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `FRAME_LEN`, 16: accepted words per frame; ≥ 1.

Ports:
- `clk_i`  in  1  single clock (datapath 100 MHz domain).
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_valid_i`  in  1  result pair valid this cycle.
- `result_i`  in  8  first datapath result byte.
- `result_2_i`  in  8  second datapath result byte.
- `m_data_o`  out  16  `{result_2_i, result_i}` of the head entry.
- `m_valid_o`  out  1  head entry valid.
- `m_ready_i`  in  1  consumer accepts head entry.
- `m_last_o`  out  1  head entry is the last word of a frame.
- `fill_o`  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- `overflow_o`  out  1  sticky: a valid pair was dropped.
- `checksum_o`  out  16  checksum of the last completed frame (see Configuration).

## Operation

- **Push:** `in_valid_i && (count < DEPTH || pop)`. The word is `{result_2_i, result_i}` plus a last bit.
- **Pop:** `m_valid_o && m_ready_i`. `m_valid_o = (count != 0)`.
- **Storage:** DEPTH×17-bit register array with wrapping `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits and a separate `count`.
- **Frame counter:**
  - `frm_cnt` counts pushes only, 0..FRAME_LEN-1. Dropped pairs do not advance it.
  - The pushed last bit is `(frm_cnt == FRAME_LEN-1)`.
  - `frm_cnt` wraps to 0 on that push.
  - With FRAME_LEN = 1, every word is last.
- **Drop:** when `in_valid_i && count == DEPTH && !pop`, the pair is discarded. `overflow_o` is set to 1 and stays 1 until `rst_i`.
- **Push and pop in the same cycle:**
  - `count` is unchanged.
  - When full, the pushed word occupies the freed slot.
  - When empty, nothing is popped because `m_valid_o` = 0. The word is pushed, `count` becomes 1, and it pops no earlier than the next cycle.
- **Stream stability:** `m_data_o`/`m_last_o` are stable while `m_valid_o && !m_ready_i`.
- **Reset values:** all outputs are 0. `wr_ptr`, `rd_ptr`, `count`, `frm_cnt` and the frame sum are also cleared.
- **Reset mid-operation:** buffered contents are discarded with no pop. The first push after reset starts frame word 0.

## Timing

- Push latency:
  - A word pushed at edge N into an empty FIFO has `m_valid_o` = 1 and data on `m_data_o` in the cycle after edge N.
  - No combinational path from `in_valid_i` to `m_valid_o`.
- `fill_o` reflects `count` after each edge. It is registered with no lookahead.
- Throughput: one push and one pop per cycle sustained.
- `m_ready_i` affects only the push-when-full decision within a cycle. There is no combinational path to `m_valid_o`.
- `overflow_o` rises in the cycle after the dropping edge.
- `checksum_o` updates in the cycle after the edge that pushes a frame's last word.

## Configuration

- Macro: `RESULT_COLLECTOR_CHECKSUM_EN`.
- **Defined:**
  - A 16-bit `frm_sum` accumulates each pushed word, mod 2^16.
  - On the push of a last word, `checksum_o <= frm_sum + word` and `frm_sum <= 0`.
  - `checksum_o` holds that value until the next frame completes.
  - Dropped pairs are excluded.
- **Undefined:**
  - No accumulator is synthesised.
  - `checksum_o` is tied to 16'h0000.
  - The port remains, so the interface is identical in both builds.

## Test plan

- **Reset values:** reset, then idle. `m_valid_o`=0, `fill_o`=0, `overflow_o`=0, `checksum_o`=0.
- **Single word:** with `m_ready_i`=1, push 0x34/0x12 → next cycle `m_data_o`=0x1234, `m_valid_o`=1; popped that cycle; `fill_o` back to 0.
- **Overflow:** DEPTH=8, `m_ready_i`=0, 9 consecutive pushes → `fill_o`=8 and `overflow_o`=1. Then ready=1 drains exactly the first 8 words in order.
- **Full with simultaneous pop:** FIFO full, `m_ready_i`=1, push 0xAA/0x55 → no drop, `overflow_o` stays 0, `fill_o` stays 8, 0x55AA emerges eighth.
- **Frame and checksum:** FRAME_LEN=4, words 0x0001..0x0004 then 0x0005 → `m_last_o` only on 0x0004, `frm_cnt` restarts at 0x0005.
  - With macro defined: `checksum_o`=0x000A.
  - Without macro: `checksum_o`=0.
- **Reset mid-operation:** reset with 3 words buffered and `overflow_o`=1 → `m_valid_o`=0 and `overflow_o`=0 next cycle. The next push is frame word 0.
